mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_feeder.sv | 111 +++++++++++
 tb/tb_mac_feeder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mac_feeder.sv
// Operand-pair buffer and sequencer that streams a dot-product job into a downstream MAC.
// Define MAC_FEEDER_SKIP_ZERO_EN to suppress mac_enable for pairs with a zero operand.
module mac_feeder #(
   parameter int DEPTH = 8,
   parameter int W     = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_x,
   input  logic [W-1:0]             wr_y,
   input  logic                     start,
   input  logic [$clog2(DEPTH):0]   len,
   input  logic [2*W-1:0]           acc_in,
   output logic                     mac_reset,
   output logic                     mac_enable,
   output logic [W-1:0]             mac_x,
   output logic [W-1:0]             mac_y,
   output logic                     busy,
   output logic                     done,
   output logic [2*W-1:0]           result
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_e;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
   } pair_t;

   state_e         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  index_q, index_d;
   logic [2*W-1:0] result_q, result_d;
   pair_t          mem_q [DEPTH];
   pair_t          mem_d [DEPTH];
   pair_t          cur_pair;

   // index is one bit wider than the address so the final increment never wraps
   assign cur_pair = mem_q[index_q[AW-1:0]];

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      index_d  = index_q;
      result_d = result_q;
      mem_d    = mem_q;
      unique case (state_q)
         IDLE: begin
            if (wr_en) mem_d[wr_addr] = '{x: wr_x, y: wr_y};
            if (start) begin
               count_d = (len > CW'(DEPTH)) ? CW'(DEPTH) : len;
               index_d = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: state_d = (count_q != '0) ? RUN : DRAIN;
         RUN: begin
            index_d = index_q + CW'(1);
            if (index_q == count_q - CW'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            result_d = acc_in;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mac_reset  = (state_q == CLEAR);
      mac_enable = 1'b0;
      mac_x      = '0;
      mac_y      = '0;
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      result     = result_q;
      if (state_q == RUN) begin
         mac_x = cur_pair.x;
         mac_y = cur_pair.y;
`ifdef MAC_FEEDER_SKIP_ZERO_EN
         mac_enable = (|cur_pair.x) && (|cur_pair.y);
`else
         mac_enable = 1'b1;
`endif
      end
   end

   // NOTE: entries live in flops, not a RAM macro, because they must read back as zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         index_q  <= '0;
         result_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         index_q  <= index_d;
         result_q <= result_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: directed scenarios plus random jobs against a behavioural model.
module tb_mac_feeder;

   localparam int DEPTH = 8;
   localparam int W     = 10;
   localparam int AW    = $clog2(DEPTH);
   localparam int ACCW  = 2 * W;

   logic            clk = 1'b0;
   logic            reset;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [W-1:0]    wr_x, wr_y;
   logic            start;
   logic [AW:0]     len;
   logic [ACCW-1:0] acc_in;
   logic            mac_reset, mac_enable, busy, done;
   logic [W-1:0]    mac_x, mac_y;
   logic [ACCW-1:0] result;

   int errors = 0;
   int checks = 0;
   int mx [DEPTH];
   int my [DEPTH];
   logic [ACCW-1:0] acc = '0;
   logic [ACCW-1:0] got;

   mac_feeder #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
      .start(start), .len(len), .acc_in(acc_in), .mac_reset(mac_reset), .mac_enable(mac_enable),
      .mac_x(mac_x), .mac_y(mac_y), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Downstream MAC: clear on mac_reset, accumulate on mac_enable, wraps modulo 2^(2W).
   always @(posedge clk) begin
      if (mac_reset) acc <= '0;
      else if (mac_enable) acc <= acc + ACCW'(mac_x) * ACCW'(mac_y);
   end
   assign acc_in = acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int a, input int x, input int y);
      wr_en = 1'b1; wr_addr = AW'(a); wr_x = W'(x); wr_y = W'(y);
      tick();
      wr_en = 1'b0;
      mx[a] = x;
      my[a] = y;
   endtask

   function automatic bit pair_enabled(input int i);
`ifdef MAC_FEEDER_SKIP_ZERO_EN
      return (mx[i] != 0) && (my[i] != 0);
`else
      return 1'b1;
`endif
   endfunction

   // Runs one job from IDLE and checks every cycle against the cycle-level timeline of a job.
   task automatic run_job(input int len_v, input bit disturb, output logic [ACCW-1:0] res);
      int     cnt, exp_done, idx;
      longint sum;
      bit     in_run, exp_en;
      int     ex, ey;
      cnt = (len_v > DEPTH) ? DEPTH : len_v;
      sum = 0;
      for (int i = 0; i < cnt; i++) sum += longint'(mx[i]) * longint'(my[i]);
      exp_done = cnt + 3;
      start = 1'b1;
      len   = (AW+1)'(len_v);
      tick();
      start = 1'b0;
      for (int c = 1; c <= exp_done + 1; c++) begin
         in_run = (c >= 2) && (c <= cnt + 1);
         idx    = in_run ? c - 2 : 0;
         exp_en = in_run && pair_enabled(idx);
         ex     = in_run ? mx[idx] : 0;
         ey     = in_run ? my[idx] : 0;
         check($sformatf("len%0d c%0d rst/en/busy/done", len_v, c),
               {28'd0, mac_reset, mac_enable, busy, done},
               {28'd0, c == 1, exp_en, c <= exp_done, c == exp_done});
         check($sformatf("len%0d c%0d operands", len_v, c), {12'd0, mac_x, mac_y},
               {12'd0, W'(ex), W'(ey)});
         if (disturb && c == 3) begin
            start = 1'b1; len = (AW+1)'(2);
            wr_en = 1'b1; wr_addr = AW'(1); wr_x = W'(9); wr_y = W'(9);
         end else if (disturb && c == 4) begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         tick();
      end
      res = result;
      check($sformatf("len%0d result", len_v), 32'(res), 32'(sum % (longint'(1) << ACCW)));
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin mx[i] = 0; my[i] = 0; end
      // Reset must win over a simultaneous start and write.
      reset = 1'b1; start = 1'b1; len = 3; wr_en = 1'b1; wr_addr = 0; wr_x = 5; wr_y = 5;
      tick(); tick();
      reset = 1'b0; start = 1'b0; wr_en = 1'b0;
      check("reset outputs", {28'd0, mac_reset, mac_enable, busy, done}, 32'd0);
      check("reset operands/result", {12'd0, mac_x, mac_y} | 32'(result), 32'd0);
      tick();
      check("reset idle busy", 32'(busy), 32'd0);
      run_job(1, 1'b0, got);

      write_entry(0, 1, 4); write_entry(1, 2, 5); write_entry(2, 3, 6);
      run_job(3, 1'b0, got);
      check("basic result 32", 32'(got), 32'd32);

      run_job(0, 1'b0, got);
      check("len0 result", 32'(got), 32'd0);

      for (int i = 0; i < DEPTH; i++) write_entry(i, 1023, 1023);
      run_job(15, 1'b0, got);
      check("clamped full-scale result", 32'(got), 32'd1032200);

      write_entry(0, 1, 4); write_entry(1, 2, 5); write_entry(2, 3, 6);
      run_job(3, 1'b1, got);
      check("disturbed job result", 32'(got), 32'd32);
      run_job(3, 1'b0, got);
      check("entry kept after ignored write", 32'(got), 32'd32);

      // Reset in the second RUN cycle.
      start = 1'b1; len = 3;
      tick();
      start = 1'b0;
      tick(); tick();
      check("pre-reset in run", {30'd0, busy, mac_enable}, 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrun reset outputs", {28'd0, mac_reset, mac_enable, busy, done}, 32'd0);
      check("midrun reset operands", {12'd0, mac_x, mac_y}, 32'd0);
      check("midrun reset result", 32'(result), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin mx[i] = 0; my[i] = 0; end
      for (int c = 0; c < 6; c++) begin
         check($sformatf("post-reset quiet c%0d", c), {30'd0, busy, done}, 32'd0);
         tick();
      end
      run_job(8, 1'b0, got);

      write_entry(0, 0, 7); write_entry(1, 2, 3);
      run_job(2, 1'b0, got);
      check("zero-operand job result", 32'(got), 32'd6);

      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < DEPTH; i++)
            write_entry(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023)),
                        ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023)));
         run_job(int'($urandom_range(0, 15)), 1'b0, got);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
